// File: rtl/seq_shift_add_multiplier_if.sv
// Start/busy/done handshake bundle for the shift-add multiplier.
// Master drives the request and operands; slave returns status and product.
interface seq_shift_add_multiplier_if #(
  parameter int A_WIDTH = 4,
  parameter int B_WIDTH = 3
);
  logic                       start;
  logic [A_WIDTH-1:0]         A;
  logic [B_WIDTH-1:0]         B;
  logic                       busy;
  logic                       done;
  logic [A_WIDTH+B_WIDTH-1:0] Y;

  modport master (
    output start, A, B,
    input  busy, done, Y
  );

  modport slave (
    input  start, A, B,
    output busy, done, Y
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// Optional SEQMUL_EARLY_TERM_EN: finish once the remaining multiplier bits are zero.
module seq_shift_add_multiplier #(
  parameter int A_WIDTH = 4,
  parameter int B_WIDTH = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  seq_shift_add_multiplier_if.slave bus
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int CW = $clog2(B_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(B_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q;
  logic [PW-1:0]      mcand_q;
  logic [PW-1:0]      acc_q;
  logic [PW-1:0]      y_q;
  logic [B_WIDTH-1:0] mreg_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;

  logic [PW-1:0]      acc_d;
  logic [B_WIDTH-1:0] mreg_d;
  logic               last_d;
  logic               accept_d;

  always_comb begin
    acc_d    = mreg_q[0] ? acc_q + mcand_q : acc_q;
    mreg_d   = mreg_q >> 1;
`ifdef SEQMUL_EARLY_TERM_EN
    // Remaining multiplier bits all zero: acc_d is already the product.
    last_d   = (cnt_q == LAST) || (mreg_d == '0);
`else
    last_d   = (cnt_q == LAST);
`endif
    accept_d = bus.start && (state_q != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      mreg_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          mreg_q  <= mreg_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            y_q     <= acc_d;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          if (accept_d) begin
            mcand_q <= PW'(bus.A);
            mreg_q  <= bus.B;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Y    = y_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: 4x3 and 8x8 multipliers against A*B and the latency rule.
// Build with +define+SEQMUL_EARLY_TERM_EN to check the early-termination variant.
module tb_seq_shift_add_multiplier;
  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  seq_shift_add_multiplier_if #(.A_WIDTH(4), .B_WIDTH(3)) bus ();
  seq_shift_add_multiplier_if #(.A_WIDTH(8), .B_WIDTH(8)) bus8 ();

  seq_shift_add_multiplier #(.A_WIDTH(4), .B_WIDTH(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  seq_shift_add_multiplier #(.A_WIDTH(8), .B_WIDTH(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RUN cycles from the accepting edge to the edge that enters DONE.
  function automatic int exp_lat(input int b, input int bw);
    int hi;
    hi = -1;
    for (int i = 0; i < bw; i++)
      if (b[i]) hi = i;
`ifdef SEQMUL_EARLY_TERM_EN
    return (hi + 1 < 1) ? 1 : hi + 1;
`else
    return bw;
`endif
  endfunction

  task automatic do_op(input int a, input int b, input string nm);
    logic [6:0] y_prev;
    int         cyc;
    int         lat;
    bit         bad;
    y_prev    = bus.Y;
    bus.start = 1'b1;
    bus.A     = 4'(a);
    bus.B     = 3'(b);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 4'($urandom);
    bus.B     = 3'($urandom);
    cyc = 1;
    bad = 1'b0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy !== 1'b1 || bus.Y !== y_prev) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    lat = exp_lat(b, 3);
    n_run++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s run_phase: busy=%b Y=%0d, required busy=1 Y=%0d",
               nm, bus.busy, bus.Y, y_prev);
    end
    n_run++;
    if (cyc - 1 !== lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d, required %0d", nm, cyc - 1, lat);
    end
    n_run++;
    if (bus.Y !== 7'(a * b) || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s product A=%0d B=%0d: Y=%0d busy=%b, required Y=%0d busy=0",
               nm, a, b, bus.Y, bus.busy, a * b);
    end
    @(negedge clk);
    n_run++;
    if (bus.done !== 1'b0 || bus.Y !== 7'(a * b)) begin
      n_fail++;
      $display("FAIL %s hold: done=%b Y=%0d, required done=0 Y=%0d",
               nm, bus.done, bus.Y, a * b);
    end
  endtask

  task automatic do_op8(input int a, input int b, input string nm);
    int cyc;
    bus8.start = 1'b1;
    bus8.A     = 8'(a);
    bus8.B     = 8'(b);
    @(negedge clk);
    bus8.start = 1'b0;
    cyc = 1;
    while (!bus8.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_run++;
    if (bus8.Y !== 16'(a * b) || cyc - 1 !== exp_lat(b, 8)) begin
      n_fail++;
      $display("FAIL %s 8x8 A=%0d B=%0d: Y=%0d lat=%0d, required Y=%0d lat=%0d",
               nm, a, b, bus8.Y, cyc - 1, a * b, exp_lat(b, 8));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Y !== 7'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b Y=%0d, required 0 0 0",
               bus.busy, bus.done, bus.Y);
    end
    n_run++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.Y !== 16'd0) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b Y=%0d, required 0 0 0",
               bus8.busy, bus8.done, bus8.Y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_op(13, 7, "basic_13x7");
    repeat (3) @(negedge clk);
    n_run++;
    if (bus.Y !== 7'd91 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle_hold: Y=%0d busy=%b, required Y=91 busy=0",
               bus.Y, bus.busy);
    end
  endtask

  task automatic test_exhaustive();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 8; b++)
        do_op(a, b, "exhaustive");
  endtask

  task automatic test_wide();
    do_op8(255, 255, "wide_max");
    for (int i = 0; i < 20; i++)
      do_op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "wide_rand");
  endtask

  task automatic test_back_to_back();
    int cyc;
    int gap;
    bus.start = 1'b1;
    bus.A     = 4'd5;
    bus.B     = 3'd3;
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_run++;
    if (bus.Y !== 7'd15) begin
      n_fail++;
      $display("FAIL b2b_first: Y=%0d, required 15", bus.Y);
    end
    bus.A = 4'd15;
    bus.B = 3'd7;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!bus.done && gap < 40);
    bus.start = 1'b0;
    n_run++;
    if (bus.Y !== 7'd105 || gap !== exp_lat(7, 3) + 1) begin
      n_fail++;
      $display("FAIL b2b_second: Y=%0d gap=%0d, required Y=105 gap=%0d",
               bus.Y, gap, exp_lat(7, 3) + 1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_busy_interference();
    int cyc;
    bus.start = 1'b1;
    bus.A     = 4'd9;
    bus.B     = 3'd6;
    @(negedge clk);
    bus.A = 4'd1;
    bus.B = 3'd1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 2;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_run++;
    if (bus.Y !== 7'd54 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ignore: Y=%0d done=%b, required Y=54 done=1",
               bus.Y, bus.done);
    end
    @(negedge clk);
    n_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore_idle: busy=%b done=%b, required 0 0",
               bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    bus.start = 1'b1;
    bus.A     = 4'd15;
    bus.B     = 3'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.Y !== 7'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: Y=%0d busy=%b done=%b, required 0 0 0",
               bus.Y, bus.busy, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    n_run++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_no_done: done pulse seen=1, required 0");
    end
    do_op(2, 2, "after_reset");
  endtask

  task automatic test_early_term();
`ifdef SEQMUL_EARLY_TERM_EN
    do_op(11, 1, "early_b1");
    do_op(11, 0, "early_b0");
    do_op(11, 4, "early_b4");
`else
    do_op(11, 1, "fixed_b1");
    do_op(11, 0, "fixed_b0");
`endif
  endtask

  initial begin
    n_run      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    bus8.start = 1'b0;
    bus8.A     = '0;
    bus8.B     = '0;
    test_reset();
    test_basic();
    test_exhaustive();
    test_wide();
    test_back_to_back();
    test_busy_interference();
    test_reset_mid_run();
    test_early_term();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
